// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Two writeback ports (ALU, load) each feed a one-entry holding buffer.
// A round-robin arbiter drains one buffer per cycle into the registered
// A3/WD3/WE3 write port. A busy scoreboard tracks destinations reserved
// at issue and not yet written back.

// One-entry holding buffer for a single writeback port.
module regfile_wb_buf #(
   parameter int AW = 5,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          drain,
   input  logic [AW-1:0] in_addr,
   input  logic [DW-1:0] in_data,
   output logic          full,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] data
);

   // A same-edge load wins over drain so a granted buffer can refill at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full <= 1'b0;
         addr <= '0;
         data <= '0;
      end else if (load) begin
         full <= 1'b1;
         addr <= in_addr;
         data <= in_data;
      end else if (drain) begin
         full <= 1'b0;
      end
   end

endmodule

module regfile_wb_arbiter #(
   parameter int AW = 5,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            p0_valid,
   input  logic [AW-1:0]   p0_addr,
   input  logic [DW-1:0]   p0_data,
   output logic            p0_ready,
   input  logic            p1_valid,
   input  logic [AW-1:0]   p1_addr,
   input  logic [DW-1:0]   p1_data,
   output logic            p1_ready,
   input  logic            rsv_valid,
   input  logic [AW-1:0]   rsv_addr,
   output logic [AW-1:0]   A3,
   output logic [DW-1:0]   WD3,
   output logic            WE3,
   output logic [(1<<AW)-1:0] busy,
   output logic            rsv_conflict
);

   localparam int NP   = 2;
   localparam int NREG = 1 << AW;

   logic [NP-1:0]         in_valid;
   logic [NP-1:0][AW-1:0] in_addr;
   logic [NP-1:0][DW-1:0] in_data;
   logic [NP-1:0]         full, grant, ready, xfer;
   logic [NP-1:0][AW-1:0] baddr;
   logic [NP-1:0][DW-1:0] bdata;

   // last = index of the port granted most recently; 1 after reset so
   // port 0 takes the first tie.
   logic                  last;
   logic                  gnt_any;
   logic [AW-1:0]         gnt_addr;
   logic [DW-1:0]         gnt_data;
   logic [NREG-1:0]       busy_nxt;

   assign in_valid = {p1_valid, p0_valid};
   assign in_addr  = {p1_addr,  p0_addr};
   assign in_data  = {p1_data,  p0_data};

   // Round-robin pick: a lone full buffer wins, a tie goes to the port
   // that was not granted last.
   always_comb begin
      grant = '0;
      if (full[0] && (!full[1] || last))
         grant[0] = 1'b1;
      else if (full[1])
         grant[1] = 1'b1;
   end

   assign ready    = ~full | grant;
   assign xfer     = in_valid & ready;
   assign p0_ready = ready[0];
   assign p1_ready = ready[1];

   assign gnt_any  = |grant;
   assign gnt_addr = grant[1] ? baddr[1] : baddr[0];
   assign gnt_data = grant[1] ? bdata[1] : bdata[0];

   for (genvar k = 0; k < NP; k++) begin : g_buf
      regfile_wb_buf #(.AW(AW), .DW(DW)) u_buf (
         .clk     (clk),
         .rst     (rst),
         .load    (xfer[k]),
         .drain   (grant[k]),
         .in_addr (in_addr[k]),
         .in_data (in_data[k]),
         .full    (full[k]),
         .addr    (baddr[k]),
         .data    (bdata[k])
      );
   end

   // Pointer moves only when something is actually granted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last <= 1'b1;
      else if (gnt_any)
         last <= grant[1];
   end

   // Registered write port; x0 grants burn the slot without a write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         A3  <= '0;
         WD3 <= '0;
         WE3 <= 1'b0;
      end else if (gnt_any && (gnt_addr != '0)) begin
         A3  <= gnt_addr;
         WD3 <= gnt_data;
         WE3 <= 1'b1;
      end else begin
         WE3 <= 1'b0;
      end
   end

   // Scoreboard next state: writeback clears, then reservation sets so a
   // same-edge reserve of the written register keeps it busy.
   always_comb begin
      busy_nxt = busy;
      if (gnt_any && (gnt_addr != '0))
         busy_nxt[gnt_addr] = 1'b0;
      if (rsv_valid && (rsv_addr != '0))
         busy_nxt[rsv_addr] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         busy <= '0;
      else
         busy <= busy_nxt;
   end

   assign rsv_conflict = rsv_valid & (rsv_addr != '0) & busy[rsv_addr];

endmodule
